// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide SPI master shift engine.
// Build option: SPI_LSB_FIRST_EN selects LSB-first bit order (see spi_master_core).
package spi_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DIV_W_DEF  = 6;

    // Bit positions inside mode: [1]=CPOL, [0]=CPHA
    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } spi_state_e;

endpackage

// File: rtl/spi_master_core_if.sv
// Bundles the register-side controls and the SPI pins of spi_master_core.
// The master modport is the shift engine; the slave modport is its environment.
interface spi_master_core_if import spi_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
);

    logic [DIV_W-1:0]  clk_div_i;
    logic [1:0]        mode_i;
    logic [DATA_W-1:0] data_i;
    logic              write_enable;
    logic              miso_i;
    logic              busy_o;
    logic [DATA_W-1:0] data_o;
    logic              sclk_o;
    logic              mosi_o;
    logic              cs_n_o;

    modport master (
        input  clk_div_i, mode_i, data_i, write_enable, miso_i,
        output busy_o, data_o, sclk_o, mosi_o, cs_n_o
    );

    modport slave (
        output clk_div_i, mode_i, data_i, write_enable, miso_i,
        input  busy_o, data_o, sclk_o, mosi_o, cs_n_o
    );

endinterface

// File: rtl/spi_clk_tick.sv
// SCLK half-period timer: counts 0..div and pulses tick for one cycle at the
// terminal count, then wraps. Held at zero while clear is high.
module spi_clk_tick import spi_pkg::*; #(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = enable && !clear && (count == div);

    // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// Byte-wide SPI master: IDLE -> SETUP -> SHIFT -> HOLD, modes 0-3, programmable SCLK.
// Define SPI_LSB_FIRST_EN for LSB-first tx/rx; the default build is MSB first.
module spi_master_core import spi_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              Pclk,
    input  logic              Preset,
    spi_master_core_if.master bus
);

    localparam int                EDGE_W    = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    spi_state_e        state, state_next;
    logic [DIV_W-1:0]  div_q;
    logic              cpha_q;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic [DATA_W-1:0] tx_shifted, rx_shifted, rx_next;
    logic [EDGE_W-1:0] edge_cnt;
    logic              sclk_q, busy_q, cs_n_q;
    logic [DATA_W-1:0] data_q;
    logic              tick, start, edge_tick, last_edge, leading, sample, drive;

    spi_clk_tick #(.DIV_W(DIV_W)) u_tick (
        .clk    (Pclk),
        .rst    (Preset),
        .clear  (state == IDLE),
        .enable (state != IDLE),
        .div    (div_q),
        .tick   (tick)
    );

    // The wire always carries the head of tx_sr; only the head position depends on bit order.
`ifdef SPI_LSB_FIRST_EN
    assign bus.mosi_o = tx_sr[0];
    assign tx_shifted = {1'b0, tx_sr[DATA_W-1:1]};
    assign rx_shifted = {bus.miso_i, rx_sr[DATA_W-1:1]};
`else
    assign bus.mosi_o = tx_sr[DATA_W-1];
    assign tx_shifted = {tx_sr[DATA_W-2:0], 1'b0};
    assign rx_shifted = {rx_sr[DATA_W-2:0], bus.miso_i};
`endif

    assign last_edge = (edge_cnt == LAST_EDGE);
    assign leading   = ~edge_cnt[0];
    assign sample    = edge_tick && (leading ^ cpha_q);
    assign drive     = edge_tick && (cpha_q ? (leading && (edge_cnt != '0))
                                            : (!leading && !last_edge));
    assign rx_next   = sample ? rx_shifted : rx_sr;

    always_ff @(posedge Pclk) begin
        if (Preset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        edge_tick  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.write_enable) begin
                    start      = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                edge_tick = tick;
                if (tick) state_next = SHIFT;
            end
            SHIFT: begin
                edge_tick = tick;
                if (tick && last_edge) state_next = HOLD;
            end
            HOLD: begin
                if (tick) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            div_q    <= '0;
            cpha_q   <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
            sclk_q   <= 1'b0;
            busy_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            data_q   <= '0;
        end else begin
            busy_q <= (state_next != IDLE);
            cs_n_q <= (state_next == IDLE);
            if (state == IDLE) begin
                sclk_q   <= bus.mode_i[CPOL_BIT];
                edge_cnt <= '0;
                if (start) begin
                    div_q  <= bus.clk_div_i;
                    cpha_q <= bus.mode_i[CPHA_BIT];
                    tx_sr  <= bus.data_i;
                    rx_sr  <= '0;
                end
            end else if (edge_tick) begin
                sclk_q   <= ~sclk_q;
                edge_cnt <= edge_cnt + EDGE_W'(1);
                rx_sr    <= rx_next;
                if (drive)     tx_sr  <= tx_shifted;
                if (last_edge) data_q <= rx_next;
            end
        end
    end

    assign bus.sclk_o = sclk_q;
    assign bus.busy_o = busy_q;
    assign bus.cs_n_o = cs_n_q;
    assign bus.data_o = data_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: a behavioural SPI slave (or loopback) on the
// pins, frame timing measured cycle by cycle, hand-computed expected bytes.
module tb_spi_master_core;

    logic Pclk;
    logic Preset;
    int   checks = 0;
    int   errors = 0;

    spi_master_core_if #(.DATA_W(8), .DIV_W(6)) bus ();

    spi_master_core #(.DATA_W(8), .DIV_W(6)) dut (
        .Pclk   (Pclk),
        .Preset (Preset),
        .bus    (bus)
    );

    initial begin
        Pclk = 1'b0;
        forever #5 Pclk = ~Pclk;
    end

    // Slave model: shifts slv_wire out first-bit-first and collects mosi the same way.
    logic       slv_cpol = 1'b0;
    logic       slv_cpha = 1'b0;
    logic [7:0] slv_wire = 8'h00;
    logic [7:0] slv_got  = 8'h00;
    logic       slv_miso = 1'b0;
    logic       loopback = 1'b0;
    logic       slv_cs_prev   = 1'b1;
    logic       slv_sclk_prev = 1'b0;
    int         slv_idx = 0;

    assign bus.miso_i = loopback ? bus.mosi_o : slv_miso;

    always @(bus.sclk_o or bus.cs_n_o) begin
        if (slv_cs_prev === 1'b1 && bus.cs_n_o === 1'b0) begin
            slv_got = 8'h00;
            slv_idx = 0;
            if (!slv_cpha) begin
                slv_miso = slv_wire[7];
                slv_idx  = 1;
            end
        end else if (bus.cs_n_o === 1'b0 && bus.sclk_o !== slv_sclk_prev) begin
            if ((bus.sclk_o != slv_cpol) != slv_cpha) begin
                slv_got = {slv_got[6:0], bus.mosi_o};
            end else if (slv_idx < 8) begin
                slv_miso = slv_wire[7 - slv_idx];
                slv_idx++;
            end
        end
        slv_cs_prev   = bus.cs_n_o;
        slv_sclk_prev = bus.sclk_o;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one frame from a negedge in IDLE and leaves the bench at the first idle negedge.
    task automatic run_frame(input string tag, input logic [5:0] div, input logic [1:0] mode,
                             input logic [7:0] tx, input logic [7:0] slave_byte, input logic lb,
                             input logic b2b, input int inject_edge, input int abort_edge,
                             input int exp_busy, input logic [7:0] exp_rx, input logic [7:0] exp_wire);
        int   busy_cyc = 0;
        int   cs_low   = 0;
        int   toggles  = 0;
        int   run      = 0;
        int   bad_run  = 0;
        int   guard    = 0;
        logic injected = 1'b0;
        logic prev;

        slv_cpol = mode[1];
        slv_cpha = mode[0];
        slv_wire = slave_byte;
        loopback = lb;
        bus.clk_div_i = div;
        bus.mode_i    = mode;
        bus.data_i    = tx;
        if (!b2b) begin
            @(negedge Pclk);
            check({tag, ":idle_sclk"}, 32'(bus.sclk_o), 32'(mode[1]));
        end
        bus.write_enable = 1'b1;
        @(negedge Pclk);
        bus.write_enable = 1'b0;
        check({tag, ":busy_on_start"}, 32'(bus.busy_o), 32'd1);

        prev = mode[1];
        while (bus.busy_o === 1'b1 && guard < 4000) begin
            guard++;
            busy_cyc++;
            if (bus.cs_n_o === 1'b0) cs_low++;
            if (bus.sclk_o !== prev) begin
                toggles++;
                if (run != int'(div) + 1) bad_run++;
                run  = 1;
                prev = bus.sclk_o;
            end else begin
                run++;
            end
            if (toggles == inject_edge && !injected) begin
                bus.write_enable = 1'b1;
                bus.data_i       = 8'hFF;
                bus.clk_div_i    = 6'd0;
                injected         = 1'b1;
            end else begin
                bus.write_enable = 1'b0;
            end
            if (toggles == abort_edge) begin
                Preset = 1'b1;
                @(negedge Pclk);
                check({tag, ":abort_cs_n"}, 32'(bus.cs_n_o), 32'd1);
                check({tag, ":abort_busy"}, 32'(bus.busy_o), 32'd0);
                check({tag, ":abort_data"}, 32'(bus.data_o), 32'h00);
                Preset = 1'b0;
                return;
            end
            @(negedge Pclk);
        end
        if (run != int'(div) + 1) bad_run++;

        check({tag, ":busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
        check({tag, ":cs_low_cycles"}, 32'(cs_low), 32'(exp_busy));
        check({tag, ":sclk_edges"}, 32'(toggles), 32'd16);
        check({tag, ":bad_half_periods"}, 32'(bad_run), 32'd0);
        check({tag, ":mosi_wire"}, 32'(slv_got), 32'(exp_wire));
        check({tag, ":data_o"}, 32'(bus.data_o), 32'(exp_rx));
    endtask

    initial begin
        int busy_seen;

        Preset           = 1'b1;
        bus.clk_div_i    = 6'd0;
        bus.mode_i       = 2'b11;
        bus.data_i       = 8'h00;
        bus.write_enable = 1'b1;
        repeat (3) @(negedge Pclk);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_cs_n", 32'(bus.cs_n_o), 32'd1);
        check("rst_sclk", 32'(bus.sclk_o), 32'd0);
        check("rst_mosi", 32'(bus.mosi_o), 32'd0);
        check("rst_data", 32'(bus.data_o), 32'h00);
        bus.write_enable = 1'b0;
        Preset           = 1'b0;
        @(negedge Pclk);
        check("idle_sclk_follows_cpol", 32'(bus.sclk_o), 32'd1);
        check("idle_cs_n", 32'(bus.cs_n_o), 32'd1);

        // mode 0, fastest clock: wire 1,0,1,0,0,1,0,1 and slave byte 0x3C
        run_frame("m0_a5", 6'd0, 2'b00, 8'hA5, 8'h3C, 1'b0, 1'b0, -1, -1, 17, 8'h3C, 8'hA5);
        // mode 3, four-cycle half-periods
        run_frame("m3_81", 6'd3, 2'b11, 8'h81, 8'hC3, 1'b0, 1'b0, -1, -1, 68, 8'hC3, 8'h81);
        // loopback in modes 1 and 2, then a start in the very first idle cycle
        run_frame("m1_lb", 6'd1, 2'b01, 8'h5A, 8'h00, 1'b1, 1'b0, -1, -1, 34, 8'h5A, 8'h5A);
        run_frame("m2_lb", 6'd0, 2'b10, 8'h5A, 8'h00, 1'b1, 1'b0, -1, -1, 17, 8'h5A, 8'h5A);
        run_frame("m2_b2b", 6'd0, 2'b10, 8'h24, 8'h00, 1'b1, 1'b1, -1, -1, 17, 8'h24, 8'h24);

        // start pulse plus new data/divider during edge 5 must not disturb or queue
        run_frame("inject", 6'd1, 2'b00, 8'h3C, 8'h99, 1'b0, 1'b0, 5, -1, 34, 8'h99, 8'h3C);
        busy_seen = 0;
        repeat (12) begin
            @(negedge Pclk);
            if (bus.busy_o !== 1'b0) busy_seen++;
        end
        check("inject:no_second_frame", 32'(busy_seen), 32'd0);
        check("inject:data_o_holds", 32'(bus.data_o), 32'h99);

        // reset in the middle of a frame, then a clean frame
        run_frame("abort", 6'd2, 2'b00, 8'h3C, 8'h66, 1'b0, 1'b0, -1, 8, 51, 8'h66, 8'h3C);
        run_frame("after_abort", 6'd2, 2'b00, 8'h3C, 8'h66, 1'b0, 1'b0, -1, -1, 51, 8'h66, 8'h3C);

        // bit order
`ifdef SPI_LSB_FIRST_EN
        run_frame("order_lsb", 6'd0, 2'b00, 8'h01, 8'h01, 1'b0, 1'b0, -1, -1, 17, 8'h80, 8'h80);
`else
        run_frame("order_msb", 6'd0, 2'b00, 8'h01, 8'h80, 1'b0, 1'b0, -1, -1, 17, 8'h80, 8'h01);
`endif

        repeat (2) @(negedge Pclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
